fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 pc  input  32  current PC from the PC register.
REQ-004 pcNext  output  32  next PC value driven to the PC register.
REQ-005 pcEn  output  1  PC register shall latch pcNext only on cycles where pcEn=1.
REQ-006 redirect  input  1  branch/jump taken, single-cycle pulse from execute.
REQ-007 redirectTarget  input  32  target address, valid while redirect=1.
REQ-008 imemReq  output  1  instruction memory request valid.
REQ-009 imemAddr  output  32  request address.
REQ-010 imemGnt  input  1  memory accepts request this cycle.
REQ-011 imemRvalid  input  1  read data valid.
REQ-012 imemRdata  input  32  read data.
REQ-013 instr  output  32  fetched instruction to decode.
REQ-014 instrPc  output  32  address of instr.
REQ-015 instrValid  output  1  instr/instrPc valid.
REQ-016 instrReady  input  1  decode accepts instruction.
REQ-017 misaligned  output  1  sticky flag: a redirect target had bits [1:0] nonzero.

Function
REQ-018 FSM states IDLE, REQ, WAIT, OUT, all registered; one-hot or binary encoding is free.
REQ-019 IDLE -> REQ unconditionally on the first clock after reset release.
REQ-020 REQ: imemReq=1, imemAddr=pc, held stable until imemGnt=1; on imemGnt -> WAIT.
REQ-021 WAIT: imemReq=0; imemRvalid=1 -> capture imemRdata into instr, captured address into instrPc, -> OUT.
REQ-022 imemRvalid is ignored in every state other than WAIT.
REQ-023 OUT: instrValid=1; instr and instrPc held stable until transfer; transfer -> REQ.
REQ-024 transfer = instrValid & instrReady & ~redirect.
REQ-025 pcEn = redirect | transfer (combinational).
REQ-026 pcNext = redirect ? {redirectTarget[31:2],2'b00} : pc + 4, using 32-bit modulo arithmetic; 0xFFFFFFFC + 4 wraps to 0x00000000.
REQ-027 Minimum latency: gnt in cycle N, rvalid in N+1, instrValid=1 in N+2.
REQ-028 Redirect in REQ without gnt -> stay in REQ; imemAddr follows the new pc on the next cycle.
REQ-029 Redirect in REQ with gnt in the same cycle -> WAIT with kill=1.
REQ-030 Redirect in WAIT without rvalid -> set kill=1 and stay in WAIT.
REQ-031 Redirect in WAIT with rvalid in the same cycle -> drop the data and go to REQ.
REQ-032 WAIT with kill=1 and rvalid=1 -> drop the data, clear kill, go to REQ; instrValid stays 0.
REQ-033 Redirect in OUT -> drop the held instruction, instrValid=0 next cycle, go to REQ.
REQ-034 Redirect overrides instrReady when both are asserted in the same cycle.
REQ-035 misaligned is set when redirect=1 and redirectTarget[1:0]!=0; it clears only on reset.
REQ-036 At most one outstanding memory request at any time.

Reset
REQ-037 rst_n=0 asynchronously forces: state=IDLE, kill=0, instr=0, instrPc=0, instrValid=0, misaligned=0.
REQ-038 While rst_n=0: imemReq=0, pcEn=0.
REQ-039 Reset asserted mid-operation (WAIT/OUT) abandons the transaction; any late rvalid after release is ignored until the next WAIT.

Verification
REQ-040 Reset release, pc=0, gnt in REQ, rvalid=1 one cycle later with 0x00000013, instrReady=1 -> instrValid=1 with instr=0x00000013, instrPc=0; pcEn=1 for one cycle; pcNext=0x4.
REQ-041 gnt held 0 for 3 cycles at pc=0x8 -> imemReq and imemAddr=0x8 stable for all 4 cycles; pcEn=0 throughout.
REQ-042 instrReady=0 for 5 cycles in OUT -> instr and instrPc unchanged; no new imemReq issued; pcEn=0.
REQ-043 redirect to 0x100 in WAIT, rvalid 2 cycles later -> no instrValid; next imemAddr=0x100.
REQ-044 redirect to 0x102 -> pcNext=0x100, misaligned=1 until reset.
REQ-045 redirect and instrReady asserted together in OUT -> no transfer; pcNext=target; instrValid=0 next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect/kill handling.
// Drives the PC register, the imem request channel and the decode handshake.
module fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic [31:0] pcNext,
    output logic        pcEn,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    output logic        instrValid,
    input  logic        instrReady,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        OUT
    } state_t;

    state_t      state;
    logic        kill;
    logic [31:0] req_addr;
    logic        xfer;

    assign xfer     = instrValid & instrReady & ~redirect;
    assign imemReq  = (state == REQ);
    assign imemAddr = pc;
    assign pcEn     = rst_n & (redirect | xfer);
    assign pcNext   = redirect ? {redirectTarget[31:2], 2'b00}
                               : pc + 32'd4;

    // fetch sequencing; kill marks an in-flight response that a redirect made stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            kill       <= 1'b0;
            req_addr   <= 32'd0;
            instr      <= 32'd0;
            instrPc    <= 32'd0;
            instrValid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (imemGnt) begin
                        state    <= WAIT;
                        req_addr <= pc;
                        kill     <= redirect;
                    end
                end
                WAIT: begin
                    if (imemRvalid) begin
                        kill <= 1'b0;
                        if (kill | redirect) begin
                            state <= REQ;
                        end else begin
                            instr      <= imemRdata;
                            instrPc    <= req_addr;
                            instrValid <= 1'b1;
                            state      <= OUT;
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end
                OUT: begin
                    if (redirect | xfer) begin
                        instrValid <= 1'b0;
                        state      <= REQ;
                    end
                end
            endcase
        end
    end

    // sticky record of any redirect to a non word-aligned target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned <= 1'b0;
        end else if (redirect && (redirectTarget[1:0] != 2'b00)) begin
            misaligned <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus, transaction-level reference model
// compared every cycle, plus literal spot checks.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] pcNext;
    logic        pcEn;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic        instrValid;
    logic        instrReady;
    logic        misaligned;

    int ncmp;
    int nerr;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .pcNext         (pcNext),
        .pcEn           (pcEn),
        .redirect       (redirect),
        .redirectTarget (redirectTarget),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemGnt        (imemGnt),
        .imemRvalid     (imemRvalid),
        .imemRdata      (imemRdata),
        .instr          (instr),
        .instrPc        (instrPc),
        .instrValid     (instrValid),
        .instrReady     (instrReady),
        .misaligned     (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // the PC register owned by the surrounding core
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 32'd0;
        else if (pcEn) pc <= pcNext;
    end

    // reference model: which phase of a fetch the unit is in
    bit          m_started;
    bit          m_busy;
    bit          m_doomed;
    bit          m_held;
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    bit          m_mis;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 0;
            m_busy    <= 0;
            m_doomed  <= 0;
            m_held    <= 0;
            m_addr    <= 0;
            m_instr   <= 0;
            m_ipc     <= 0;
            m_mis     <= 0;
        end else begin
            if (redirect && redirectTarget[1:0] != 2'b00) m_mis <= 1;
            if (!m_started) begin
                m_started <= 1;
            end else if (m_held) begin
                if (redirect || instrReady) m_held <= 0;
            end else if (m_busy) begin
                if (imemRvalid) begin
                    m_busy   <= 0;
                    m_doomed <= 0;
                    if (!(m_doomed || redirect)) begin
                        m_held  <= 1;
                        m_instr <= imemRdata;
                        m_ipc   <= m_addr;
                    end
                end else if (redirect) begin
                    m_doomed <= 1;
                end
            end else if (imemGnt) begin
                m_busy   <= 1;
                m_addr   <= pc;
                m_doomed <= redirect;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        logic        e_req;
        logic        e_pcen;
        logic [31:0] e_next;
        e_req  = rst_n && m_started && !m_busy && !m_held;
        e_pcen = rst_n && (redirect || (m_held && instrReady));
        e_next = redirect ? {redirectTarget[31:2], 2'b00} : pc + 32'd4;
        chk("m_imemReq", {31'd0, imemReq}, {31'd0, e_req});
        if (e_req) chk("m_imemAddr", imemAddr, pc);
        chk("m_instrValid", {31'd0, instrValid}, {31'd0, m_held});
        chk("m_instr", instr, m_instr);
        chk("m_instrPc", instrPc, m_ipc);
        chk("m_pcEn", {31'd0, pcEn}, {31'd0, e_pcen});
        chk("m_pcNext", pcNext, e_next);
        chk("m_misaligned", {31'd0, misaligned}, {31'd0, m_mis});
    end

    // one cycle of stimulus; returns just after the compare point
    task automatic drive(input logic g, input logic rv,
                         input logic [31:0] rd, input logic rdy,
                         input logic rdr, input logic [31:0] tg);
        @(posedge clk);
        #1;
        imemGnt        = g;
        imemRvalid     = rv;
        imemRdata      = rd;
        instrReady     = rdy;
        redirect       = rdr;
        redirectTarget = tg;
        @(negedge clk);
        #1;
    endtask

    task automatic idle1();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        rst_n = 0;
        imemGnt = 0;
        imemRvalid = 0;
        imemRdata = 0;
        instrReady = 0;
        redirect = 0;
        redirectTarget = 0;
        #2;
        chk("rst_instrValid", {31'd0, instrValid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        drive(0, 0, 0, 0, 1, 32'h40);
        chk("rst_pcEn", {31'd0, pcEn}, 32'd0);
        chk("rst_imemReq", {31'd0, imemReq}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        redirect = 0;
        @(negedge clk);
        #1;
        chk("idle_req", {31'd0, imemReq}, 32'd0);
        // first fetch, minimum latency
        drive(1, 0, 0, 0, 0, 0);
        chk("f1_req", {31'd0, imemReq}, 32'd1);
        chk("f1_addr", imemAddr, 32'h0);
        drive(0, 1, 32'h13, 0, 0, 0);
        chk("f1_wait_req", {31'd0, imemReq}, 32'd0);
        drive(0, 0, 0, 1, 0, 0);
        chk("f1_valid", {31'd0, instrValid}, 32'd1);
        chk("f1_instr", instr, 32'h13);
        chk("f1_ipc", instrPc, 32'h0);
        chk("f1_pcEn", {31'd0, pcEn}, 32'd1);
        chk("f1_pcNext", pcNext, 32'h4);
        // second fetch at 0x4
        drive(1, 0, 0, 0, 0, 0);
        chk("f2_addr", imemAddr, 32'h4);
        drive(0, 1, 32'hAAAA, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        // grant stall at 0x8
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, 0, 0, 0, 0, 0);
            chk("stall_req", {31'd0, imemReq}, 32'd1);
            chk("stall_addr", imemAddr, 32'h8);
            chk("stall_pcEn", {31'd0, pcEn}, 32'd0);
        end
        drive(0, 1, 32'h1234, 0, 0, 0);
        // decode backpressure; stray rvalid in OUT must be ignored
        for (int i = 0; i < 5; i++) begin
            drive(0, i == 2, 32'hBAD, 0, 0, 0);
            chk("bp_instr", instr, 32'h1234);
            chk("bp_ipc", instrPc, 32'h8);
            chk("bp_req", {31'd0, imemReq}, 32'd0);
            chk("bp_pcEn", {31'd0, pcEn}, 32'd0);
        end
        drive(0, 0, 0, 1, 0, 0);
        // redirect during WAIT, late response dropped
        drive(1, 0, 0, 0, 0, 0);
        chk("w_addr", imemAddr, 32'hC);
        drive(0, 0, 0, 0, 1, 32'h100);
        chk("w_pcNext", pcNext, 32'h100);
        idle1();
        drive(0, 1, 32'hDEAD, 0, 0, 0);
        idle1();
        chk("w_valid", {31'd0, instrValid}, 32'd0);
        chk("w_req", {31'd0, imemReq}, 32'd1);
        chk("w_newaddr", imemAddr, 32'h100);
        // redirect to misaligned target together with ready in OUT
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h55, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 32'h102);
        chk("o_pcNext", pcNext, 32'h100);
        chk("o_pcEn", {31'd0, pcEn}, 32'd1);
        idle1();
        chk("o_valid", {31'd0, instrValid}, 32'd0);
        chk("o_mis", {31'd0, misaligned}, 32'd1);
        chk("o_addr", imemAddr, 32'h100);
        // redirect with grant in the same cycle
        drive(1, 0, 0, 0, 1, 32'h200);
        drive(0, 1, 32'h77, 0, 0, 0);
        idle1();
        chk("g_valid", {31'd0, instrValid}, 32'd0);
        chk("g_addr", imemAddr, 32'h200);
        // redirect with rvalid in the same cycle
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h88, 0, 1, 32'h300);
        idle1();
        chk("r_valid", {31'd0, instrValid}, 32'd0);
        chk("r_addr", imemAddr, 32'h300);
        // redirect in REQ without grant, then PC wrap
        drive(0, 0, 0, 0, 1, 32'hFFFFFFFC);
        idle1();
        chk("q_req", {31'd0, imemReq}, 32'd1);
        chk("q_addr", imemAddr, 32'hFFFFFFFC);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h99, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        chk("wrap_ipc", instrPc, 32'hFFFFFFFC);
        chk("wrap_pcNext", pcNext, 32'h0);
        idle1();
        chk("wrap_addr", imemAddr, 32'h0);
        // reset in WAIT, late rvalid afterwards ignored
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 0;
        imemGnt = 0;
        redirect = 1;
        redirectTarget = 32'h500;
        @(negedge clk);
        #1;
        chk("mr_pcEn", {31'd0, pcEn}, 32'd0);
        chk("mr_req", {31'd0, imemReq}, 32'd0);
        chk("mr_mis", {31'd0, misaligned}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        redirect = 0;
        imemRvalid = 1;
        imemRdata = 32'hBEEF;
        @(negedge clk);
        #1;
        drive(0, 1, 32'hBEEF, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("late_valid", {31'd0, instrValid}, 32'd0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 32'hABC, 0, 0, 0);
        idle1();
        chk("post_instr", instr, 32'hABC);
        chk("post_ipc", instrPc, 32'h0);
        drive(0, 0, 0, 1, 0, 0);
        idle1();
        idle1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
